// File: rtl/ws28xx_strip_driver.sv
// Serial LED strip driver: fetches pixels from a 1-cycle-latency RAM port and
// emits WS28xx-style pulse-width symbols, followed by a low latch period.
module ws28xx_strip_driver #(
  parameter int LED_COUNT      = 64,
  parameter int ADDR_WIDTH     = 9,
  parameter int BITS_PER_PIXEL = 24,
  parameter int REVERSE        = 0,
  parameter int CYCLES_0_HIGH  = 21,
  parameter int CYCLES_1_HIGH  = 42,
  parameter int CYCLES_BIT     = 63,
  parameter int CYCLES_RESET   = 2600
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      continuous_i,
  output logic [ADDR_WIDTH-1:0]     address_o,
  input  logic [BITS_PER_PIXEL-1:0] pixel_i,
  output logic                      busy_o,
  output logic                      frame_done_o,
  output logic                      data_o
);

  localparam int PHASE_MAX = (CYCLES_BIT > CYCLES_RESET) ? CYCLES_BIT : CYCLES_RESET;
  localparam int PW        = $clog2(PHASE_MAX + 1);
  localparam int BW        = $clog2(BITS_PER_PIXEL);

  localparam logic [PW-1:0]         PH_ONE       = PW'(1);
  localparam logic [PW-1:0]         PH_HIGH0     = PW'(CYCLES_0_HIGH);
  localparam logic [PW-1:0]         PH_HIGH1     = PW'(CYCLES_1_HIGH);
  localparam logic [PW-1:0]         PH_BIT_LAST  = PW'(CYCLES_BIT - 1);
  localparam logic [PW-1:0]         PH_RST_LAST  = PW'(CYCLES_RESET - 1);
  localparam logic [BW-1:0]         BIT_FIRST    = BW'(BITS_PER_PIXEL - 1);
  localparam logic [ADDR_WIDTH-1:0] IDX_LAST     = ADDR_WIDTH'(LED_COUNT - 1);
  localparam logic [ADDR_WIDTH-1:0] IDX_END      = ADDR_WIDTH'(LED_COUNT);

  generate
    if (CYCLES_0_HIGH == 0 || CYCLES_1_HIGH >= CYCLES_BIT ||
        CYCLES_0_HIGH >= CYCLES_1_HIGH ||
        (BITS_PER_PIXEL != 24 && BITS_PER_PIXEL != 32) ||
        LED_COUNT < 1 || LED_COUNT > (1 << ADDR_WIDTH)) begin : g_bad_params
      $error("ws28xx_strip_driver: invalid parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_BIT   = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  state_t                    state_reg;
  state_t                    state_next;
  logic [PW-1:0]             phase_reg;
  logic [BW-1:0]             bit_cnt_reg;
  logic [ADDR_WIDTH-1:0]     index_reg;
  logic [BITS_PER_PIXEL-1:0] shift_reg;
  logic                      data_reg;

  logic fetch_end;
  logic bit_end;
  logic last_bit;
  logic last_pixel;
  logic latch_end;
  logic symbol_level;

  assign fetch_end    = (phase_reg == PH_ONE);
  assign bit_end      = (phase_reg == PH_BIT_LAST);
  assign last_bit     = (bit_cnt_reg == '0);
  // index_reg already points one past the pixel on the wire (prefetch)
  assign last_pixel   = (index_reg == IDX_END);
  assign latch_end    = (phase_reg == PH_RST_LAST);
  assign symbol_level = (phase_reg < (shift_reg[BITS_PER_PIXEL-1] ? PH_HIGH1 : PH_HIGH0));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start_i || continuous_i) state_next = S_FETCH;
      S_FETCH: if (fetch_end) state_next = S_BIT;
      S_BIT:   if (bit_end && last_bit && last_pixel) state_next = S_LATCH;
      S_LATCH: if (latch_end) state_next = continuous_i ? S_FETCH : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o       = (state_reg != S_IDLE);
    frame_done_o = (state_reg == S_LATCH) && latch_end;
    address_o    = (REVERSE != 0) ? (IDX_LAST - index_reg) : index_reg;
    data_o       = data_reg;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_reg   <= '0;
      bit_cnt_reg <= '0;
      index_reg   <= '0;
      shift_reg   <= '0;
      data_reg    <= 1'b0;
    end else begin
      data_reg <= (state_reg == S_BIT) && symbol_level;
      case (state_reg)
        S_IDLE: begin
          phase_reg <= '0;
          index_reg <= '0;
        end
        S_FETCH: begin
          if (fetch_end) begin
            shift_reg   <= pixel_i;
            index_reg   <= index_reg + 1'b1;
            bit_cnt_reg <= BIT_FIRST;
            phase_reg   <= '0;
          end else begin
            phase_reg <= phase_reg + 1'b1;
          end
        end
        S_BIT: begin
          if (bit_end) begin
            phase_reg <= '0;
            if (!last_bit) begin
              shift_reg   <= shift_reg << 1;
              bit_cnt_reg <= bit_cnt_reg - 1'b1;
            end else if (!last_pixel) begin
              // next pixel was prefetched during this one: no inter-pixel gap
              shift_reg   <= pixel_i;
              index_reg   <= index_reg + 1'b1;
              bit_cnt_reg <= BIT_FIRST;
            end else begin
              index_reg <= '0;
            end
          end else begin
            phase_reg <= phase_reg + 1'b1;
          end
        end
        S_LATCH: begin
          phase_reg <= latch_end ? '0 : phase_reg + 1'b1;
        end
        default: begin
          phase_reg <= '0;
        end
      endcase
    end
  end

endmodule
